// File: rtl/operand_bank_if.sv
// Bus/compute-side signal bundle for operand_bank; master drives requests, slave is the bank store.
interface operand_bank_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIM    = 4,
  parameter int BANK_W     = 1,
  parameter int IDX_W      = 2
);
  logic                                  wr_en_i;
  logic [BANK_W-1:0]                     wr_bank_i;
  logic [IDX_W-1:0]                      wr_row_i;
  logic [DATA_WIDTH*MAX_DIM-1:0]         wr_data_i;
  logic [MAX_DIM-1:0]                    wr_strb_i;
  logic                                  wr_err_o;
  logic                                  rd_en_i;
  logic [BANK_W-1:0]                     rd_bank_i;
  logic                                  rd_sel_col_i;
  logic [IDX_W-1:0]                      rd_idx_i;
  logic [DATA_WIDTH*MAX_DIM-1:0]         rd_data_o;
  logic                                  rd_valid_o;
  logic [IDX_W:0]                        dim_rows_i;
  logic [IDX_W:0]                        dim_cols_i;
  logic                                  transpose_i;
  logic                                  swap_req_i;
  logic                                  swap_ack_o;
  logic                                  clr_req_i;
  logic [BANK_W-1:0]                     clr_bank_i;
  logic                                  busy_o;
  logic [BANK_W-1:0]                     active_bank_o;
  logic [DATA_WIDTH*MAX_DIM*MAX_DIM-1:0] mat_flat_o;

  modport master (
    output wr_en_i, wr_bank_i, wr_row_i, wr_data_i, wr_strb_i,
    output rd_en_i, rd_bank_i, rd_sel_col_i, rd_idx_i,
    output dim_rows_i, dim_cols_i, transpose_i, swap_req_i, clr_req_i, clr_bank_i,
    input  wr_err_o, rd_data_o, rd_valid_o, swap_ack_o, busy_o, active_bank_o, mat_flat_o
  );

  modport slave (
    input  wr_en_i, wr_bank_i, wr_row_i, wr_data_i, wr_strb_i,
    input  rd_en_i, rd_bank_i, rd_sel_col_i, rd_idx_i,
    input  dim_rows_i, dim_cols_i, transpose_i, swap_req_i, clr_req_i, clr_bank_i,
    output wr_err_o, rd_data_o, rd_valid_o, swap_ack_o, busy_o, active_bank_o, mat_flat_o
  );
endinterface

// File: rtl/operand_bank.sv
// Multi-bank operand matrix store: bus writes shadow banks, compute reads the active bank flat.
// Readback 1-cycle latency; no backpressure, illegal writes are dropped and flagged via wr_err_o.
module operand_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIM    = 4,
  parameter int NUM_BANKS  = 2,
  parameter int BANK_W     = 1,
  parameter int IDX_W      = 2
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  operand_bank_if.slave bus
);
  localparam int BIDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int RIDX_W = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int DW     = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, CLEAR, SWAP} state_t;

  logic [DW-1:0]          mem [NUM_BANKS][MAX_DIM][MAX_DIM];
  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       row_cnt_q, row_cnt_d;
  logic [BANK_W-1:0]      clr_bank_q, clr_bank_d;
  logic [BANK_W-1:0]      active_q, active_d;
  logic                   swap_pend_q, swap_pend_d;
  logic                   wr_err_q, rd_valid_q;
  logic [DW*MAX_DIM-1:0]  rd_data_q, rd_word;
  logic                   wr_ok, clr_ok, busy;
  logic [BANK_W-1:0]      next_bank;

  // Narrow indices used only after the matching range check has passed.
  logic [BIDX_W-1:0] wr_b, rd_b, clr_b, act_b;
  logic [RIDX_W-1:0] wr_r, rd_r, clr_r;

  assign wr_b  = bus.wr_bank_i[BIDX_W-1:0];
  assign rd_b  = bus.rd_bank_i[BIDX_W-1:0];
  assign clr_b = clr_bank_q[BIDX_W-1:0];
  assign act_b = active_q[BIDX_W-1:0];
  assign wr_r  = bus.wr_row_i[RIDX_W-1:0];
  assign rd_r  = bus.rd_idx_i[RIDX_W-1:0];
  assign clr_r = row_cnt_q[RIDX_W-1:0];

  assign busy      = (state_q == CLEAR);
  assign clr_ok    = int'(bus.clr_bank_i) < NUM_BANKS;
  assign next_bank = (int'(active_q) >= NUM_BANKS - 1) ? '0 : active_q + BANK_W'(1);
  assign wr_ok     = (int'(bus.wr_bank_i) < NUM_BANKS) && (int'(bus.wr_row_i) < MAX_DIM) &&
                     (bus.wr_bank_i != active_q) && !(busy && (bus.wr_bank_i == clr_bank_q));

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    clr_bank_d  = clr_bank_q;
    swap_pend_d = swap_pend_q;
    active_d    = active_q;
    case (state_q)
      IDLE: begin
        if (bus.clr_req_i && clr_ok) begin
          state_d     = CLEAR;
          row_cnt_d   = '0;
          clr_bank_d  = bus.clr_bank_i;
          swap_pend_d = bus.swap_req_i;
        end else if (bus.swap_req_i) begin
          state_d  = SWAP;
          active_d = next_bank;
        end
      end
      CLEAR: begin
        if (row_cnt_q == IDX_W'(MAX_DIM - 1)) begin
          swap_pend_d = 1'b0;
          if (swap_pend_q || bus.swap_req_i) begin
            state_d  = SWAP;
            active_d = next_bank;
          end else begin
            state_d = IDLE;
          end
        end else begin
          row_cnt_d = row_cnt_q + IDX_W'(1);
          if (bus.swap_req_i) swap_pend_d = 1'b1;
        end
      end
      SWAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      clr_bank_q  <= '0;
      active_q    <= '0;
      swap_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      clr_bank_q  <= clr_bank_d;
      active_q    <= active_d;
      swap_pend_q <= swap_pend_d;
    end
  end

  // Writes never target the bank under clear, so both updates can share one process.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int r = 0; r < MAX_DIM; r++)
          for (int c = 0; c < MAX_DIM; c++)
            mem[b][r][c] <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= bus.wr_en_i && !wr_ok;
      if (bus.wr_en_i && wr_ok) begin
        for (int e = 0; e < MAX_DIM; e++)
          if (bus.wr_strb_i[e]) mem[wr_b][wr_r][e] <= bus.wr_data_i[e*DW +: DW];
      end
      if (busy) begin
        for (int e = 0; e < MAX_DIM; e++)
          mem[clr_b][clr_r][e] <= '0;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if ((int'(bus.rd_bank_i) < NUM_BANKS) && (int'(bus.rd_idx_i) < MAX_DIM)) begin
      for (int e = 0; e < MAX_DIM; e++)
        rd_word[e*DW +: DW] = bus.rd_sel_col_i ? mem[rd_b][RIDX_W'(e)][rd_r]
                                               : mem[rd_b][rd_r][RIDX_W'(e)];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en_i;
      if (bus.rd_en_i) rd_data_q <= rd_word;
    end
  end

  // Dims are compared after transpose; any dim >= MAX_DIM already passes every index.
  always_comb begin
    bus.mat_flat_o = '0;
    for (int r = 0; r < MAX_DIM; r++)
      for (int c = 0; c < MAX_DIM; c++)
        if ((r < int'(bus.dim_rows_i)) && (c < int'(bus.dim_cols_i)))
          bus.mat_flat_o[(r*MAX_DIM + c)*DW +: DW] =
            bus.transpose_i ? mem[act_b][RIDX_W'(c)][RIDX_W'(r)]
                            : mem[act_b][RIDX_W'(r)][RIDX_W'(c)];
  end

  assign bus.wr_err_o      = wr_err_q;
  assign bus.rd_data_o     = rd_data_q;
  assign bus.rd_valid_o    = rd_valid_q;
  assign bus.swap_ack_o    = (state_q == SWAP);
  assign bus.busy_o        = busy;
  assign bus.active_bank_o = active_q;
endmodule

// File: tb/tb_operand_bank.sv
// Directed bench for operand_bank: writes, readback, swap, masking, clear and async reset.
module tb_operand_bank;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   busy_cyc;
  int   ack_cnt;

  operand_bank_if #(.DATA_WIDTH(8), .MAX_DIM(4), .BANK_W(2), .IDX_W(2)) bus ();

  operand_bank #(.DATA_WIDTH(8), .MAX_DIM(4), .NUM_BANKS(2), .BANK_W(2), .IDX_W(2)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] b, input logic [1:0] r, input logic [31:0] d,
                          input logic [3:0] s);
    bus.wr_en_i   = 1'b1;
    bus.wr_bank_i = b;
    bus.wr_row_i  = r;
    bus.wr_data_i = d;
    bus.wr_strb_i = s;
    tick();
    bus.wr_en_i = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] b, input logic col, input logic [1:0] idx);
    bus.rd_en_i      = 1'b1;
    bus.rd_bank_i    = b;
    bus.rd_sel_col_i = col;
    bus.rd_idx_i     = idx;
    tick();
    bus.rd_en_i = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.wr_en_i      = 1'b0;
    bus.wr_bank_i    = '0;
    bus.wr_row_i     = '0;
    bus.wr_data_i    = '0;
    bus.wr_strb_i    = '0;
    bus.rd_en_i      = 1'b0;
    bus.rd_bank_i    = '0;
    bus.rd_sel_col_i = 1'b0;
    bus.rd_idx_i     = '0;
    bus.dim_rows_i   = 3'd4;
    bus.dim_cols_i   = 3'd4;
    bus.transpose_i  = 1'b0;
    bus.swap_req_i   = 1'b0;
    bus.clr_req_i    = 1'b0;
    bus.clr_bank_i   = '0;
    tick();
    tick();
    chk("rst_rd_data", bus.rd_data_o, 0);
    chk("rst_rd_valid", bus.rd_valid_o, 0);
    chk("rst_ack", bus.swap_ack_o, 0);
    chk("rst_wr_err", bus.wr_err_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_active", bus.active_bank_o, 0);
    chk("rst_mat", bus.mat_flat_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Strobed write into shadow bank, then readback
    do_write(2'd1, 2'd2, 32'h44332211, 4'b0101);
    chk("strb_wr_err", bus.wr_err_o, 0);
    do_read(2'd1, 1'b0, 2'd2);
    chk("strb_rd_data", bus.rd_data_o, 32'h00330011);
    chk("strb_rd_valid", bus.rd_valid_o, 1);
    tick();
    chk("rd_valid_drop", bus.rd_valid_o, 0);
    chk("rd_data_hold", bus.rd_data_o, 32'h00330011);

    // Write to active bank and to a nonexistent bank are dropped
    do_write(2'd0, 2'd0, 32'hAABBCCDD, 4'hF);
    chk("act_wr_err", bus.wr_err_o, 1);
    do_read(2'd0, 1'b0, 2'd0);
    chk("act_wr_err_once", bus.wr_err_o, 0);
    chk("act_unchanged", bus.rd_data_o, 0);
    do_write(2'd2, 2'd1, 32'h55667788, 4'hF);
    chk("oob_wr_err", bus.wr_err_o, 1);
    do_read(2'd0, 1'b0, 2'd1);
    chk("oob_no_alias", bus.rd_data_o, 0);
    do_read(2'd1, 1'b0, 2'd2);
    do_read(2'd2, 1'b0, 2'd2);
    chk("oob_rd_zero", bus.rd_data_o, 0);
    chk("oob_rd_valid", bus.rd_valid_o, 1);

    // Fill bank1 with 4r+c and swap it in
    do_write(2'd1, 2'd0, 32'h03020100, 4'hF);
    do_write(2'd1, 2'd1, 32'h07060504, 4'hF);
    do_write(2'd1, 2'd2, 32'h0B0A0908, 4'hF);
    do_write(2'd1, 2'd3, 32'h0F0E0D0C, 4'hF);
    chk("fill_wr_err", bus.wr_err_o, 0);
    bus.swap_req_i = 1'b1;
    tick();
    bus.swap_req_i = 1'b0;
    chk("swap_ack", bus.swap_ack_o, 1);
    chk("swap_active", bus.active_bank_o, 1);
    tick();
    chk("swap_ack_pulse", bus.swap_ack_o, 0);
    chk("view_row1", bus.mat_flat_o[63:32], 32'h07060504);
    bus.transpose_i = 1'b1;
    #1;
    chk("view_t_row1", bus.mat_flat_o[63:32], 32'h0D090501);
    bus.transpose_i = 1'b0;

    // Dimension masking of the compute view; readback stays raw
    bus.dim_rows_i = 3'd2;
    bus.dim_cols_i = 3'd3;
    #1;
    chk("mask_rows23", bus.mat_flat_o[127:64], 64'h0);
    chk("mask_row0", bus.mat_flat_o[31:0], 32'h00020100);
    chk("mask_row1", bus.mat_flat_o[63:32], 32'h00060504);
    do_read(2'd1, 1'b1, 2'd3);
    chk("col_rd_raw", bus.rd_data_o, 32'h0F0B0703);
    bus.dim_rows_i = 3'd0;
    #1;
    chk("mask_dim0", bus.mat_flat_o, 0);
    bus.dim_rows_i = 3'd7;
    bus.dim_cols_i = 3'd6;
    #1;
    chk("dim_clamp_row3", bus.mat_flat_o[127:96], 32'h0F0E0D0C);
    bus.dim_rows_i = 3'd4;
    bus.dim_cols_i = 3'd4;

    // Clear of the active bank with a swap requested in the same cycle
    bus.clr_req_i  = 1'b1;
    bus.clr_bank_i = 2'd1;
    bus.swap_req_i = 1'b1;
    tick();
    bus.clr_req_i  = 1'b0;
    bus.swap_req_i = 1'b0;
    busy_cyc = 0;
    ack_cnt  = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.busy_o) busy_cyc++;
      if (bus.swap_ack_o) ack_cnt++;
      if (i == 0) begin
        bus.swap_req_i = 1'b1;
        bus.wr_en_i    = 1'b1;
        bus.wr_bank_i  = 2'd1;
        bus.wr_row_i   = 2'd3;
        bus.wr_data_i  = 32'hFFFFFFFF;
        bus.wr_strb_i  = 4'hF;
      end
      if (i == 1) begin
        bus.swap_req_i = 1'b0;
        bus.wr_en_i    = 1'b0;
        chk("clr_wr_err", bus.wr_err_o, 1);
        chk("clr_row0_zero", bus.mat_flat_o[31:0], 0);
        chk("clr_row3_live", bus.mat_flat_o[127:96], 32'h0F0E0D0C);
      end
      tick();
    end
    chk("clr_busy_cycles", busy_cyc, 4);
    chk("clr_single_ack", ack_cnt, 1);
    chk("clr_active", bus.active_bank_o, 0);
    for (int r = 0; r < 4; r++) begin
      do_read(2'd1, 1'b0, r[1:0]);
      chk("clr_bank1_zero", bus.rd_data_o, 0);
    end

    // Asynchronous reset in the middle of a clear with a pending swap
    do_write(2'd1, 2'd3, 32'h11223344, 4'hF);
    do_read(2'd1, 1'b0, 2'd3);
    chk("pre_rst_rd", bus.rd_data_o, 32'h11223344);
    bus.clr_req_i  = 1'b1;
    bus.clr_bank_i = 2'd1;
    bus.swap_req_i = 1'b1;
    tick();
    bus.clr_req_i  = 1'b0;
    bus.swap_req_i = 1'b0;
    tick();
    chk("pre_rst_busy", bus.busy_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy_o, 0);
    chk("arst_active", bus.active_bank_o, 0);
    chk("arst_rd_data", bus.rd_data_o, 0);
    chk("arst_rd_valid", bus.rd_valid_o, 0);
    chk("arst_ack", bus.swap_ack_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.swap_ack_o) ack_cnt++;
    end
    chk("arst_no_ack", ack_cnt, 0);
    do_read(2'd1, 1'b0, 2'd3);
    chk("arst_storage", bus.rd_data_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/operand_bank.md
Name: operand_bank

Overview:
- Multi-bank operand matrix store for the matrix-multiply datapath.
- Successor to the single-bank operand store. Adds the following:
  - NUM_BANKS ping-pong banks.
  - Swap handshake.
  - Background bank clear FSM.
  - Row/column readback.
  - Runtime dimension masking.
  - Transposed compute view.
- Bus side writes the shadow bank(s) while the compute engine reads the active bank through a flat matrix port.

Parameters:
- DATA_WIDTH, 8, element width in bits.
- MAX_DIM, 4, matrix rows = cols = elements per row.
- NUM_BANKS, 2, number of matrix banks (>=2).
- BANK_W, 1, bank index width (>= clog2(NUM_BANKS)).
- IDX_W, 2, row/col index width (>= clog2(MAX_DIM)).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset. Asynchronous, active-low.
- wr_en_i  in  1  row write request.
- wr_bank_i  in  BANK_W  target bank.
- wr_row_i  in  IDX_W  target row.
- wr_data_i  in  DATA_WIDTH*MAX_DIM  row data; element e at [(e+1)*DATA_WIDTH-1 -: DATA_WIDTH].
- wr_strb_i  in  MAX_DIM  per-element write strobe.
- wr_err_o  out  1  one-cycle pulse: write dropped.
- rd_en_i  in  1  readback request.
- rd_bank_i  in  BANK_W  readback bank.
- rd_sel_col_i  in  1  0 = row read, 1 = column read.
- rd_idx_i  in  IDX_W  row or column index.
- rd_data_o  out  DATA_WIDTH*MAX_DIM  readback data.
- rd_valid_o  out  1  readback data valid.
- dim_rows_i  in  IDX_W+1  live row count.
- dim_cols_i  in  IDX_W+1  live column count.
- transpose_i  in  1  transpose the compute view.
- swap_req_i  in  1  advance the active bank.
- swap_ack_o  out  1  one-cycle pulse: swap done.
- clr_req_i  in  1  start zeroing a bank.
- clr_bank_i  in  BANK_W  bank to clear.
- busy_o  out  1  clear in progress.
- active_bank_o  out  BANK_W  bank driving mat_flat_o.
- mat_flat_o  out  DATA_WIDTH*MAX_DIM*MAX_DIM  active bank; row r at [(r+1)*DATA_WIDTH*MAX_DIM-1 -: DATA_WIDTH*MAX_DIM].

Behaviour:
- Reset (asynchronous on rst_n_i low):
  - All storage = 0; active_bank_o = 0.
  - rd_data_o = 0; rd_valid_o = 0.
  - swap_ack_o = 0; wr_err_o = 0; busy_o = 0.
  - FSM = IDLE; pending swap cleared.
  - Reset mid-clear or mid-swap aborts the operation; storage is zeroed anyway.
- Write:
  - Happens on the rising edge when wr_en_i is high.
  - Element e of mem[wr_bank_i][wr_row_i] takes wr_data_i element e iff wr_strb_i[e]. Other elements hold.
  - Write is dropped, with wr_err_o pulsed the next cycle, if any of:
    - wr_bank_i >= NUM_BANKS;
    - wr_row_i >= MAX_DIM;
    - wr_bank_i == active_bank_o;
    - wr_bank_i == the bank under clear while busy_o.
- Readback:
  - Registered, 1-cycle latency: rd_valid_o is rd_en_i delayed one cycle.
  - Row read: element e = mem[b][idx][e]. Column read: element e = mem[b][e][idx].
  - Data is raw, with no dimension masking.
  - Read and write to the same location in the same cycle returns the pre-write value.
  - Out-of-range bank or idx returns 0 with rd_valid_o still set.
  - rd_data_o holds its last value when rd_en_i is low.
- Compute view (combinational from the active bank):
  - Element (r,c) = transpose_i ? mem[r_src=c][c_src=r] : mem[r][c].
  - Forced to 0 if r >= dim_rows_i or c >= dim_cols_i. Dims apply after transpose.
  - Dim values > MAX_DIM are treated as MAX_DIM. A dim value of 0 zeroes the whole view.
- FSM states: IDLE, CLEAR, SWAP.
  - IDLE + clr_req_i (valid bank) -> CLEAR:
    - row counter = 0, busy_o = 1.
    - One row of clr_bank_i is zeroed per cycle, rows 0..MAX_DIM-1.
    - After the last row -> IDLE (or SWAP if a swap is pending). busy_o deasserts with the exit edge.
    - A clear takes exactly MAX_DIM cycles of busy_o.
  - IDLE + swap_req_i -> SWAP:
    - active_bank_o <= (active_bank_o + 1) mod NUM_BANKS, so it wraps from NUM_BANKS-1 to 0.
    - swap_ack_o pulses for 1 cycle, then -> IDLE.
  - swap_req_i during CLEAR is latched pending. It is serviced immediately after the clear, with one ack. Repeated requests while pending collapse into one.
  - clr_req_i and swap_req_i together in IDLE: clear first, swap pending.
  - clr_req_i while busy_o, or with an invalid bank: ignored.
  - Clearing the active bank is permitted; mat_flat_o shows rows going to 0 as they clear.

Test Plan:
- Reset then write bank1 row2 data 0x44332211, strb 4'b0101, active = 0 -> bank1 row2 = 0x00330011; row read of bank1 idx2 next cycle gives 0x00330011 with rd_valid_o = 1.
- Write bank0 while active_bank_o = 0 -> wr_err_o pulses once; row read of bank0 shows data unchanged. Same result for wr_bank_i = 2 with NUM_BANKS = 2.
- Fill bank1 with element(r,c) = 4r+c, swap_req_i -> swap_ack_o one cycle later, active_bank_o = 1. mat_flat_o row1 = 0x07060504. With transpose_i = 1, row1 = 0x0D090501.
- Bank1 active, dim_rows_i = 2, dim_cols_i = 3 -> mat_flat_o rows 2..3 = 0 and element 3 of rows 0..1 = 0. Column read of bank1 idx3 = 0x0F0B0703, unmasked.
- clr_req_i bank1 and swap_req_i in the same cycle -> busy_o high for exactly 4 cycles, bank1 all 0, then a single swap_ack_o and active_bank_o = 0. A write to bank1 mid-clear raises wr_err_o.
- Assert rst_n_i low asynchronously on cycle 2 of a clear -> busy_o = 0 immediately, all storage and outputs 0, no swap_ack_o after release.
